execute_stage_mc: RTL and testbench

- Parametrised, multi-cycle execute stage. Sits between the decode/ID-EX pipeline register and the EX-MEM register.
- Selects operands through two source muxes and two forwarding muxes, then runs them through the ALU.
- Adds an iterative unsigned multiplier and restoring divider, with a stall handshake towards the hazard unit.
- Keeps the CNZ flag register, including flag restore from write-back (RTI path).

---
 rtl/execute_stage_mc.sv | 213 +++++++++++++++++++++
 tb/tb_execute_stage_mc.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_mc.sv
// Multi-cycle execute stage: operand/forwarding muxes, single-cycle ALU,
// iterative shift-add multiplier and restoring divider, CNZ flag register.
module execute_stage_mc #(
  parameter int W   = 16,
  parameter int SHW = 4,
  parameter int CW  = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [3:0]     op,
  input  logic [1:0]     src_sel,
  input  logic [1:0]     dst_sel,
  input  logic [1:0]     fu_src_sel,
  input  logic [1:0]     fu_dst_sel,
  input  logic           flags_en,
  input  logic           flags_wb,
  input  logic [2:0]     flags_wb_val,
  input  logic [W-1:0]   rsrc,
  input  logic [W-1:0]   rdst,
  input  logic [W-1:0]   imm,
  input  logic [W-1:0]   sp_low,
  input  logic [W-1:0]   in_port,
  input  logic [SHW-1:0] shamt,
  input  logic [W-1:0]   fwd_em,
  input  logic [W-1:0]   fwd_wb,
  input  logic [W-1:0]   fwd_mw,
  output logic [W-1:0]   result,
  output logic [W-1:0]   result_hi,
  output logic           out_valid,
  output logic           stall,
  output logic [2:0]     flags_out,
  output logic [W-1:0]   sp_before
);

  localparam logic [3:0] OP_MOV = 4'd1, OP_NOT = 4'd2, OP_INC = 4'd3, OP_DEC = 4'd4;
  localparam logic [3:0] OP_ADD = 4'd5, OP_SUB = 4'd6, OP_AND = 4'd7, OP_OR  = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9, OP_SHR = 4'd10, OP_MUL = 4'd11, OP_DIV = 4'd12;
  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d, acc_q, acc_d, lo_q, lo_d;
  logic           fen_q, fen_d;
  logic [W-1:0]   result_q, result_d, result_hi_q, result_hi_d;
  logic           out_valid_q, out_valid_d;
  logic [2:0]     flags_q, flags_d;

  logic [W-1:0]   a_mux, b_mux, opa, opb;
  logic [W:0]     alu_ext;
  logic [W-1:0]   alu_res;
  logic           alu_c, alu_fupd;
  logic [W:0]     mul_sum, div_sh, div_diff;
  logic           div_ge;

  always_comb begin
    case (src_sel)
      2'd1:    a_mux = in_port;
      2'd2:    a_mux = imm;
      default: a_mux = rsrc;
    endcase
    case (fu_src_sel)
      2'd1:    opa = fwd_wb;
      2'd2:    opa = fwd_em;
      default: opa = a_mux;
    endcase
    case (dst_sel)
      2'd1:    b_mux = W'(shamt);
      2'd2:    b_mux = sp_low;
      default: b_mux = rdst;
    endcase
    case (fu_dst_sel)
      2'd1:    opb = fwd_wb;
      2'd2:    opb = fwd_em;
      2'd3:    opb = fwd_mw;
      default: opb = b_mux;
    endcase
  end

  assign sp_before = opb;

  always_comb begin
    alu_ext  = '0;
    alu_res  = '0;
    alu_c    = flags_q[2];
    alu_fupd = 1'b1;
    case (op)
      OP_MOV: alu_res = opa;
      OP_NOT: alu_res = ~opa;
      OP_INC: begin alu_ext = {1'b0, opa} + ONE;         alu_res = alu_ext[W-1:0]; alu_c = alu_ext[W]; end
      OP_DEC: begin alu_ext = {1'b0, opa} - ONE;         alu_res = alu_ext[W-1:0]; alu_c = alu_ext[W]; end
      OP_ADD: begin alu_ext = {1'b0, opa} + {1'b0, opb}; alu_res = alu_ext[W-1:0]; alu_c = alu_ext[W]; end
      OP_SUB: begin alu_ext = {1'b0, opb} - {1'b0, opa}; alu_res = alu_ext[W-1:0]; alu_c = alu_ext[W]; end
      OP_AND: alu_res = opa & opb;
      OP_OR:  alu_res = opa | opb;
      // One guard bit beyond the word catches the last bit shifted out.
      OP_SHL: begin
        alu_ext = {1'b0, opb} << shamt;
        alu_res = alu_ext[W-1:0];
        if (shamt != '0) alu_c = alu_ext[W];
      end
      OP_SHR: begin
        alu_ext = {opb, 1'b0} >> shamt;
        alu_res = alu_ext[W:1];
        if (shamt != '0) alu_c = alu_ext[0];
      end
      default: alu_fupd = 1'b0;
    endcase
  end

  // acc/lo hold {hi, lo} of the product for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_sh   = {acc_q, lo_q[W-1]};
    div_ge   = (div_sh >= {1'b0, a_q});
    div_diff = div_sh - {1'b0, a_q};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    fen_d       = fen_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    out_valid_d = 1'b0;
    flags_d     = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL || op == OP_DIV) begin
            a_d     = opa;
            acc_d   = '0;
            lo_d    = opb;
            cnt_d   = CW'(W);
            fen_d   = flags_en;
            state_d = (op == OP_MUL) ? S_MUL : S_DIV;
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            out_valid_d = 1'b1;
            if (flags_en && alu_fupd)
              flags_d = {alu_c, alu_res[W-1], alu_res == '0};
          end
        end
      end
      S_MUL: begin
        acc_d = mul_sum[W:1];
        lo_d  = {mul_sum[0], lo_q[W-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_IDLE;
          result_d    = lo_d;
          result_hi_d = acc_d;
          out_valid_d = 1'b1;
          if (fen_q) flags_d = {acc_d != '0, lo_d[W-1], lo_d == '0};
        end
      end
      S_DIV: begin
        // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
        acc_d = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
        lo_d  = {lo_q[W-2:0], div_ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_IDLE;
          result_d    = lo_d;
          result_hi_d = acc_d;
          out_valid_d = 1'b1;
          if (fen_q) flags_d = {a_q == '0, lo_d[W-1], lo_d == '0};
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flags_wb) flags_d = flags_wb_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      fen_q       <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      fen_q       <= fen_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign out_valid = out_valid_q;
  assign stall     = (state_q != S_IDLE);
  assign flags_out = flags_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Self-checking bench for execute_stage_mc: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_execute_stage_mc;
  localparam int W = 16, SHW = 4, CW = 5;
  localparam longint M = longint'(1) << W;

  logic clk = 1'b0;
  logic rst, in_valid, flags_en, flags_wb;
  logic [3:0] op;
  logic [1:0] src_sel, dst_sel, fu_src_sel, fu_dst_sel;
  logic [2:0] flags_wb_val;
  logic [W-1:0] rsrc, rdst, imm, sp_low, in_port, fwd_em, fwd_wb, fwd_mw;
  logic [SHW-1:0] shamt;
  logic [W-1:0] result, result_hi, sp_before;
  logic out_valid, stall;
  logic [2:0] flags_out;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_flags;

  execute_stage_mc #(.W(W), .SHW(SHW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op),
    .src_sel(src_sel), .dst_sel(dst_sel), .fu_src_sel(fu_src_sel), .fu_dst_sel(fu_dst_sel),
    .flags_en(flags_en), .flags_wb(flags_wb), .flags_wb_val(flags_wb_val),
    .rsrc(rsrc), .rdst(rdst), .imm(imm), .sp_low(sp_low), .in_port(in_port),
    .shamt(shamt), .fwd_em(fwd_em), .fwd_wb(fwd_wb), .fwd_mw(fwd_mw),
    .result(result), .result_hi(result_hi), .out_valid(out_valid), .stall(stall),
    .flags_out(flags_out), .sp_before(sp_before)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint pick_a();
    longint m;
    case (src_sel) 2'd1: m = in_port; 2'd2: m = imm; default: m = rsrc; endcase
    case (fu_src_sel) 2'd1: m = fwd_wb; 2'd2: m = fwd_em; default: ; endcase
    return m;
  endfunction

  function automatic longint pick_b();
    longint m;
    case (dst_sel) 2'd1: m = shamt; 2'd2: m = sp_low; default: m = rdst; endcase
    case (fu_dst_sel) 2'd1: m = fwd_wb; 2'd2: m = fwd_em; 2'd3: m = fwd_mw; default: ; endcase
    return m;
  endfunction

  // Reference model: plain arithmetic on the operand values, updates exp_flags.
  task automatic model(input int o, input longint a, input longint b, input int sh, input bit fen,
                       output longint r, output longint hi, output bit multi);
    bit c, upd;
    c = exp_flags[2]; upd = 1'b1; r = 0; hi = 0; multi = 1'b0;
    case (o)
      1:  r = a;
      2:  r = (M - 1) - a;
      3:  begin r = (a + 1) % M; c = (a + 1) >= M; end
      4:  begin r = (a + M - 1) % M; c = (a == 0); end
      5:  begin r = (a + b) % M; c = (a + b) >= M; end
      6:  begin r = (b - a + M) % M; c = (a > b); end
      7:  r = a & b;
      8:  r = a | b;
      9:  begin r = (b << sh) % M; if (sh != 0) c = ((b >> (W - sh)) & 1) != 0; end
      10: begin r = b >> sh;      if (sh != 0) c = ((b >> (sh - 1)) & 1) != 0; end
      11: begin multi = 1'b1; r = (a * b) % M; hi = (a * b) / M; c = (hi != 0); end
      12: begin
        multi = 1'b1;
        if (a == 0) begin r = M - 1; hi = b; c = 1'b1; end
        else begin r = b / a; hi = b % a; c = 1'b0; end
      end
      default: upd = 1'b0;
    endcase
    if (fen && upd) exp_flags = {c, r >= M / 2, r == 0};
  endtask

  task automatic set_ctl(input logic [3:0] o, input logic [1:0] ss, input logic [1:0] ds,
                         input logic [1:0] fs, input logic [1:0] fd, input logic fen);
    op = o; src_sel = ss; dst_sel = ds; fu_src_sel = fs; fu_dst_sel = fd; flags_en = fen;
  endtask

  function automatic logic [W-1:0] rnd_w();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic scramble();
    rsrc = rnd_w(); rdst = rnd_w(); imm = rnd_w(); sp_low = rnd_w(); in_port = rnd_w();
    fwd_em = rnd_w(); fwd_wb = rnd_w(); fwd_mw = rnd_w(); shamt = SHW'($urandom);
  endtask

  // Called at a negedge with inputs set; returns at the negedge where out_valid is seen.
  task automatic issue(input string tag);
    longint a, b, r, hi;
    bit multi;
    int n, k;
    a = pick_a();
    b = pick_b();
    #1 check({tag, "/sp_before"}, sp_before, b);
    model(int'(op), a, b, int'(shamt), flags_en, r, hi, multi);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (multi) scramble();
    n = 0; k = 0;
    @(negedge clk);
    while (!out_valid && k < 3 * W) begin
      if (stall) n++;
      k++;
      @(negedge clk);
    end
    check({tag, "/wait"}, k, multi ? W : 0);
    check({tag, "/stall_cycles"}, n, multi ? W : 0);
    check({tag, "/valid"}, out_valid, 1);
    check({tag, "/stall_done"}, stall, 0);
    check({tag, "/result"}, result, r);
    check({tag, "/result_hi"}, result_hi, hi);
    check({tag, "/flags"}, flags_out, exp_flags);
  endtask

  initial begin
    int n;
    rst = 1'b0; in_valid = 1'b0; flags_wb = 1'b0; flags_wb_val = '0;
    set_ctl(4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    rsrc = '0; rdst = '0; imm = '0; sp_low = '0; in_port = '0;
    fwd_em = '0; fwd_wb = '0; fwd_mw = '0; shamt = '0;
    exp_flags = 3'b000;
    repeat (3) @(negedge clk);
    check("rst/result", result, 0);
    check("rst/result_hi", result_hi, 0);
    check("rst/out_valid", out_valid, 0);
    check("rst/stall", stall, 0);
    check("rst/flags", flags_out, 0);
    rst = 1'b1;
    @(negedge clk);

    set_ctl(4'd5, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1); rsrc = 16'hFFFF; rdst = 16'h0001;
    issue("add_wrap");
    check("add_wrap/flags_const", flags_out, 3'b101);

    set_ctl(4'd3, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1); rsrc = 16'hFFFF;
    issue("inc_wrap");
    check("inc_wrap/flags_const", flags_out, 3'b101);

    set_ctl(4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    issue("nop");

    set_ctl(4'd11, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1); rsrc = 16'd7; rdst = 16'd9;
    issue("mul_7x9");
    check("mul_7x9/result_const", result, 16'h003F);

    set_ctl(4'd11, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1); rsrc = 16'hFFFF; rdst = 16'hFFFF;
    issue("mul_max");
    check("mul_max/hi_const", result_hi, 16'hFFFE);

    set_ctl(4'd12, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1); rsrc = 16'd7; rdst = 16'd100;
    issue("div_100_7");
    check("div_100_7/q_const", result, 16'd14);

    set_ctl(4'd12, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1); rsrc = 16'd0; rdst = 16'h1234;
    issue("div_zero");
    check("div_zero/flags_const", flags_out, 3'b110);

    set_ctl(4'd6, 2'd0, 2'd0, 2'd2, 2'd3, 1'b1); fwd_em = 16'h0005; fwd_mw = 16'h0003;
    issue("fwd_sub");
    check("fwd_sub/result_const", result, 16'hFFFE);
    check("fwd_sub/sp_before_const", sp_before, 16'h0003);

    // Flag restore while the multiplier is busy.
    set_ctl(4'd11, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1); rsrc = 16'd3; rdst = 16'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    flags_wb = 1'b1; flags_wb_val = 3'b010;
    @(posedge clk);
    #1 flags_wb = 1'b0;
    check("wb_stall/flags", flags_out, 3'b010);
    check("wb_stall/stall", stall, 1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 3 * W) begin n++; @(negedge clk); end
    check("wb_stall/valid", out_valid, 1);
    check("wb_stall/result", result, 16'd15);
    check("wb_stall/flags_done", flags_out, 3'b000);
    exp_flags = 3'b000;

    // Write-back on the completion edge wins over the multiplier's flag update.
    set_ctl(4'd11, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1); rsrc = 16'hFFFF; rdst = 16'hFFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (W - 1) @(posedge clk);
    #1 flags_wb = 1'b1; flags_wb_val = 3'b011;
    @(posedge clk);
    #1 flags_wb = 1'b0;
    check("wb_done/valid", out_valid, 1);
    check("wb_done/result", result, 16'h0001);
    check("wb_done/flags", flags_out, 3'b011);
    exp_flags = 3'b011;
    @(negedge clk);

    // Reset in the middle of a divide.
    set_ctl(4'd12, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1); rsrc = 16'd7; rdst = 16'd100;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_div/stall", stall, 0);
    check("rst_div/out_valid", out_valid, 0);
    check("rst_div/result", result, 0);
    check("rst_div/flags", flags_out, 0);
    exp_flags = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    repeat (2 * W) begin @(negedge clk); if (out_valid) n++; end
    check("rst_div/no_valid", n, 0);
    set_ctl(4'd5, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1); rsrc = 16'd2; rdst = 16'd3;
    issue("post_rst_add");
    check("post_rst_add/result_const", result, 16'd5);

    for (int i = 0; i < 200; i++) begin
      set_ctl(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 2'($urandom),
              2'($urandom), 1'($urandom));
      scramble();
      issue($sformatf("rand%0d_op%0d", i, op));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
